// File: rtl/mips_pkg.sv
// Shared types and constants for the next-PC unit: FSM state encoding, reset vector,
// instruction field widths and the branch displacement helper.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0040_0000;
  localparam int          OFFSET_W         = 16;
  localparam int          INDEX_W          = 26;

  // Word offset -> sign-extended byte displacement.
  function automatic logic [31:0] branch_disp(input logic [OFFSET_W-1:0] off);
    return {{(32-OFFSET_W-2){off[OFFSET_W-1]}}, off, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_unit_if.sv
// Instruction-fetch request bus between the next-PC unit (master) and memory (slave).
interface next_pc_unit_if;
  // Handshake: the master raises Fetch_req_out and holds Fetch_addr_out stable until the
  // slave answers Fetch_ack_in=1; the transfer completes on the rising edge where both are 1.
  // Fetch_ack_in is meaningless while Fetch_req_out=0.
  logic        Fetch_req_out;
  logic [31:0] Fetch_addr_out;
  logic        Fetch_ack_in;

  modport master (output Fetch_req_out, output Fetch_addr_out, input Fetch_ack_in);
  modport slave  (input Fetch_req_out, input Fetch_addr_out, output Fetch_ack_in);
endinterface

// File: rtl/next_pc_target.sv
// Combinational next-address selection: register jump, J-format jump, taken branch or PC+4.
module next_pc_target
  import mips_pkg::*;
(
  input  logic [31:0]         pc_i,
  input  logic                branch_i,
  input  logic                jump_i,
  input  logic                jump_reg_i,
  input  logic [31:0]         target_i,
  input  logic [OFFSET_W-1:0] offset_i,
  input  logic [INDEX_W-1:0]  index_i,
  output logic [31:0]         pc_plus4_o,
  output logic [31:0]         next_addr_o
);

  always_comb begin
    pc_plus4_o = pc_i + 32'd4;
    // Jump outranks branch when the ALU reports both.
    if (jump_i && jump_reg_i)
      next_addr_o = target_i;
    else if (jump_i)
      next_addr_o = {pc_plus4_o[31:28], index_i, 2'b00};
    else if (branch_i)
      next_addr_o = pc_plus4_o + branch_disp(offset_i);
    else
      next_addr_o = pc_plus4_o;
  end

endmodule

// File: rtl/next_pc_unit.sv
// Next-PC unit: FETCH/EXEC/HALT sequencer for a MIPS-style fetch path.
// Optional branch delay slot with macro NEXT_PC_DELAY_SLOT_EN.
module next_pc_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic                Inst_valid_in,
  input  logic                Branch_in,
  input  logic                Jump_in,
  input  logic                JumpReg_in,
  input  logic [31:0]         Target_in,
  input  logic [OFFSET_W-1:0] BranchOffset_in,
  input  logic [INDEX_W-1:0]  JumpIndex_in,
  next_pc_unit_if.master      fetch,
  output logic [31:0]         PC_out,
  output logic [31:0]         Link_out,
  output logic                Inst_valid_out,
  output logic                AddrErr_out,
  output state_t              State_out
);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_addr_q, fetch_addr_d;
  logic        inst_valid_q, inst_valid_d;
  logic        addr_err_q, addr_err_d;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_addr;
  logic [31:0] sel_addr;

`ifdef NEXT_PC_DELAY_SLOT_EN
  logic [31:0] pending_q, pending_d;
  logic        pend_valid_q, pend_valid_d;
`endif

  next_pc_target u_target (
    .pc_i        (pc_q),
    .branch_i    (Branch_in),
    .jump_i      (Jump_in),
    .jump_reg_i  (JumpReg_in),
    .target_i    (Target_in),
    .offset_i    (BranchOffset_in),
    .index_i     (JumpIndex_in),
    .pc_plus4_o  (pc_plus4),
    .next_addr_o (redirect_addr)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fetch_addr_d = fetch_addr_q;
    inst_valid_d = 1'b0;
    addr_err_d   = addr_err_q;
    sel_addr     = redirect_addr;
`ifdef NEXT_PC_DELAY_SLOT_EN
    pending_d    = pending_q;
    pend_valid_d = pend_valid_q;
`endif

    case (state_q)
      ST_FETCH: begin
        if (fetch.Fetch_ack_in) begin
          pc_d         = fetch_addr_q;
          inst_valid_d = 1'b1;
          state_d      = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (Inst_valid_in) begin
`ifdef NEXT_PC_DELAY_SLOT_EN
          // The slot instruction's own control-flow decision is dropped.
          if (pend_valid_q) begin
            sel_addr     = pending_q;
            pend_valid_d = 1'b0;
          end else if (Jump_in || Branch_in) begin
            pending_d    = redirect_addr;
            pend_valid_d = 1'b1;
            sel_addr     = pc_plus4;
          end
`endif
          if (sel_addr[1:0] != 2'b00) begin
            addr_err_d = 1'b1;
            state_d    = ST_HALT;
          end else begin
            fetch_addr_d = sel_addr;
            state_d      = ST_FETCH;
          end
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= ST_FETCH;
      pc_q         <= RESET_VECTOR;
      fetch_addr_q <= RESET_VECTOR;
      inst_valid_q <= 1'b0;
      addr_err_q   <= 1'b0;
`ifdef NEXT_PC_DELAY_SLOT_EN
      pending_q    <= 32'd0;
      pend_valid_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fetch_addr_q <= fetch_addr_d;
      inst_valid_q <= inst_valid_d;
      addr_err_q   <= addr_err_d;
`ifdef NEXT_PC_DELAY_SLOT_EN
      pending_q    <= pending_d;
      pend_valid_q <= pend_valid_d;
`endif
    end
  end

  // Gated by reset so the request falls the instant reset asserts, not at the next edge.
  assign fetch.Fetch_req_out  = rst_n_in && (state_q == ST_FETCH);
  assign fetch.Fetch_addr_out = fetch_addr_q;
  assign PC_out               = pc_q;
  assign Inst_valid_out       = inst_valid_q;
  assign AddrErr_out          = addr_err_q;
  assign State_out            = state_q;

`ifdef NEXT_PC_DELAY_SLOT_EN
  assign Link_out = pc_plus4 + 32'd4;
`else
  assign Link_out = pc_plus4;
`endif

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed self-checking bench for next_pc_unit (default build, or delay-slot build
// when NEXT_PC_DELAY_SLOT_EN is defined).
module tb_next_pc_unit;
  import mips_pkg::*;

  localparam logic [31:0] RV = 32'h0040_0000;
`ifdef NEXT_PC_DELAY_SLOT_EN
  localparam logic [31:0] LINK_INC = 32'd8;
`else
  localparam logic [31:0] LINK_INC = 32'd4;
`endif

  logic                clk;
  logic                rst_n;
  logic                inst_valid;
  logic                branch;
  logic                jump;
  logic                jump_reg;
  logic [31:0]         target;
  logic [OFFSET_W-1:0] offset;
  logic [INDEX_W-1:0]  index;
  logic [31:0]         pc;
  logic [31:0]         link;
  logic                iv_out;
  logic                addr_err;
  state_t              dut_state;

  int n_tests = 0;
  int n_fail  = 0;

  next_pc_unit_if fetch_bus ();

  next_pc_unit #(.RESET_VECTOR(RV)) dut (
    .clk_in          (clk),
    .rst_n_in        (rst_n),
    .Inst_valid_in   (inst_valid),
    .Branch_in       (branch),
    .Jump_in         (jump),
    .JumpReg_in      (jump_reg),
    .Target_in       (target),
    .BranchOffset_in (offset),
    .JumpIndex_in    (index),
    .fetch           (fetch_bus.master),
    .PC_out          (pc),
    .Link_out        (link),
    .Inst_valid_out  (iv_out),
    .AddrErr_out     (addr_err),
    .State_out       (dut_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic clear_exec();
    inst_valid = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    jump_reg   = 1'b0;
    target     = 32'd0;
    offset     = '0;
    index      = '0;
  endtask

  // Present one execute result for one clock.
  task automatic exec(input logic br, input logic jp, input logic jr,
                      input logic [31:0] tgt, input logic [15:0] off, input logic [25:0] idx);
    inst_valid = 1'b1;
    branch     = br;
    jump       = jp;
    jump_reg   = jr;
    target     = tgt;
    offset     = off;
    index      = idx;
    @(posedge clk); #1;
    clear_exec();
  endtask

  // Wait (bounded) for a request, check its address, acknowledge it, check the EXEC entry.
  task automatic do_fetch(input logic [31:0] exp_addr);
    int n = 0;
    while (!fetch_bus.Fetch_req_out && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("fetch_req", 32'(fetch_bus.Fetch_req_out), 32'd1);
    check("fetch_addr", fetch_bus.Fetch_addr_out, exp_addr);
    fetch_bus.Fetch_ack_in = 1'b1;
    @(posedge clk); #1;
    fetch_bus.Fetch_ack_in = 1'b0;
    check("pc_load", pc, exp_addr);
    check("inst_valid_pulse", 32'(iv_out), 32'd1);
    check("link", link, exp_addr + LINK_INC);
  endtask

  initial begin
    rst_n = 1'b0;
    fetch_bus.Fetch_ack_in = 1'b0;
    clear_exec();
    #12;
    check("rst_req", 32'(fetch_bus.Fetch_req_out), 32'd0);
    check("rst_addr", fetch_bus.Fetch_addr_out, RV);
    check("rst_pc", pc, RV);
    check("rst_iv", 32'(iv_out), 32'd0);
    check("rst_err", 32'(addr_err), 32'd0);
    check("rst_state", 32'(dut_state), 32'(ST_FETCH));

    @(negedge clk); rst_n = 1'b1; #1;
    check("first_req", 32'(fetch_bus.Fetch_req_out), 32'd1);
    check("first_addr", fetch_bus.Fetch_addr_out, RV);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("wait_req", 32'(fetch_bus.Fetch_req_out), 32'd1);
      check("wait_addr", fetch_bus.Fetch_addr_out, RV);
    end
    fetch_bus.Fetch_ack_in = 1'b1;
    @(posedge clk); #1;
    fetch_bus.Fetch_ack_in = 1'b0;
    check("ack_pc", pc, RV);
    check("ack_iv", 32'(iv_out), 32'd1);
    check("ack_req_low", 32'(fetch_bus.Fetch_req_out), 32'd0);
    check("ack_state", 32'(dut_state), 32'(ST_EXEC));
    check("ack_link", link, RV + LINK_INC);
    @(posedge clk); #1;
    check("iv_one_cycle", 32'(iv_out), 32'd0);
    check("exec_hold_pc", pc, RV);

`ifdef NEXT_PC_DELAY_SLOT_EN
    // Branch at 0x00400000 to 0x00400100: offset = (0x100 - 4) >> 2 = 0x3F.
    exec(1'b1, 1'b0, 1'b0, 32'd0, 16'h003F, 26'd0);
    do_fetch(32'h0040_0004);
    // Slot instruction reports a branch which must be ignored.
    exec(1'b1, 1'b0, 1'b0, 32'd0, 16'h0010, 26'd0);
    do_fetch(32'h0040_0100);
    exec(1'b0, 1'b0, 1'b0, 32'd0, 16'h0000, 26'd0);
    do_fetch(32'h0040_0104);
`else
    for (int i = 1; i <= 4; i++) begin
      exec(1'b0, 1'b0, 1'b0, 32'd0, 16'h0000, 26'd0);
      do_fetch(RV + 32'(4 * i));
    end
    // PC 0x00400010: 0x00400014 + (-4 << 2) = 0x00400004.
    exec(1'b1, 1'b0, 1'b0, 32'd0, 16'hFFFC, 26'd0);
    do_fetch(32'h0040_0004);
    exec(1'b0, 1'b1, 1'b1, 32'h0040_0010, 16'h0000, 26'd0);
    do_fetch(32'h0040_0010);
    exec(1'b0, 1'b0, 1'b0, 32'd0, 16'hFFFC, 26'd0);
    // Execute result presented during FETCH must not disturb the pending request.
    inst_valid = 1'b1; jump = 1'b1; jump_reg = 1'b1; target = 32'h1234_5678;
    @(posedge clk); #1;
    clear_exec();
    do_fetch(32'h0040_0014);

    exec(1'b0, 1'b1, 1'b1, 32'h1040_0000, 16'h0000, 26'd0);
    do_fetch(32'h1040_0000);
    exec(1'b0, 1'b1, 1'b0, 32'd0, 16'h0000, 26'h000_0100);
    do_fetch(32'h1000_0400);
    exec(1'b0, 1'b1, 1'b1, 32'h1040_0000, 16'h0000, 26'd0);
    do_fetch(32'h1040_0000);
    exec(1'b1, 1'b1, 1'b0, 32'd0, 16'h0010, 26'h000_0100);
    do_fetch(32'h1000_0400);

    // Wrap-around: link at 0xFFFFFFFC is 0, next fetch is 0.
    exec(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 16'h0000, 26'd0);
    do_fetch(32'hFFFF_FFFC);
    exec(1'b0, 1'b0, 1'b0, 32'd0, 16'h0000, 26'd0);
    do_fetch(32'h0000_0000);

    // Misaligned register target halts the unit.
    exec(1'b0, 1'b1, 1'b1, 32'h0040_0002, 16'h0000, 26'd0);
    check("halt_err", 32'(addr_err), 32'd1);
    check("halt_req", 32'(fetch_bus.Fetch_req_out), 32'd0);
    check("halt_state", 32'(dut_state), 32'(ST_HALT));
    fetch_bus.Fetch_ack_in = 1'b1;
    inst_valid = 1'b1; jump = 1'b1; jump_reg = 1'b1; target = 32'h0040_0008;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("halt_hold_req", 32'(fetch_bus.Fetch_req_out), 32'd0);
      check("halt_hold_err", 32'(addr_err), 32'd1);
    end
    fetch_bus.Fetch_ack_in = 1'b0;
    clear_exec();

    rst_n = 1'b0; #1;
    check("rerst_err", 32'(addr_err), 32'd0);
    check("rerst_pc", pc, RV);
    check("rerst_req", 32'(fetch_bus.Fetch_req_out), 32'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    check("restart_req", 32'(fetch_bus.Fetch_req_out), 32'd1);
    check("restart_addr", fetch_bus.Fetch_addr_out, RV);

    // Reset mid-fetch drops the request with no clock edge in between.
    @(posedge clk); #3;
    rst_n = 1'b0; #1;
    check("async_req_drop", 32'(fetch_bus.Fetch_req_out), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    do_fetch(RV);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
